br_amba_apb_demux: RTL
======================

Name: br_amba_apb_demux

Overview:
- APB fan-out stage that consumes a single APB manager stream, such as the output of the AXI4-Lite-to-APB bridge, and routes each transfer to one of NumSubordinates APB subordinates by address decode.
- Fully registers the downstream request.
- Terminates unmapped addresses locally with an error response.
- Bounds every downstream access with a timeout counter, so a hung subordinate can never stall the upstream bus.

Parameters:
- AddrWidth, 12: address width, upstream and downstream; must be >= SubAddrWidth + clog2(NumSubordinates).
- DataWidth, 32: data width; must be >= 32 and a multiple of 8.
- NumSubordinates, 4: number of downstream APB ports; must be >= 2.
- SubAddrWidth, 10: each subordinate owns a 2^SubAddrWidth-byte window. Index = paddr[SubAddrWidth +: clog2(NumSubordinates)].
- TimeoutCycles, 256: maximum Access-phase cycles before forced error; 0 disables the timeout; otherwise must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- paddr  in  AddrWidth  upstream address
- psel  in  1  upstream select
- penable  in  1  upstream enable
- pprot  in  br_amba::ApbProtWidth  upstream protection
- pstrb  in  DataWidth/8  upstream write strobes
- pwrite  in  1  upstream direction
- pwdata  in  DataWidth  upstream write data
- prdata  out  DataWidth  upstream read data
- pready  out  1  upstream ready
- pslverr  out  1  upstream error
- m_psel  out  NumSubordinates  one-hot downstream select
- m_penable  out  1  shared downstream enable
- m_paddr  out  AddrWidth  shared downstream address (full, undecoded)
- m_pprot  out  br_amba::ApbProtWidth  shared protection
- m_pstrb  out  DataWidth/8  shared strobes
- m_pwrite  out  1  shared direction
- m_pwdata  out  DataWidth  shared write data
- m_prdata  in  NumSubordinates*DataWidth  per-subordinate read data; subordinate i at [i*DataWidth +: DataWidth]
- m_pready  in  NumSubordinates  per-subordinate ready
- m_pslverr  in  NumSubordinates  per-subordinate error

Behaviour:
- Reset: clk and rst_n as above; asynchronous active-low. While rst_n=0:
  - state=Idle.
  - All outputs 0: pready, pslverr, prdata, m_psel, m_penable, m_paddr, m_pprot, m_pstrb, m_pwrite, m_pwdata.
  - Timeout counter = 0.
- Reset mid-transfer: m_psel and m_penable drop asynchronously. The upstream transfer is abandoned; no response is issued.
- FSM, one-hot states Idle, Setup, Access, Done.
- Idle:
  - On psel=1 and penable=0 (upstream setup phase), capture paddr, pprot, pstrb, pwrite and pwdata into the downstream registers.
  - Decode idx.
  - If idx < NumSubordinates, go to Setup. Otherwise go to Done with resp_err=1 and rdata=0.
- Setup: m_psel[idx]=1, m_penable=0. Next state is Access, unconditionally.
- Access: m_psel[idx]=1, m_penable=1; counter increments each cycle.
  - If m_pready[idx]=1: capture m_prdata slice idx and m_pslverr[idx] into the response registers, then go to Done.
  - Else if TimeoutCycles != 0 and counter == TimeoutCycles-1: resp_err=1, rdata=0, go to Done. m_psel drops, which is a deliberate subordinate-side abort.
  - Captured read data is forwarded on writes too; the upstream ignores it.
- Done:
  - m_psel=0 and m_penable=0.
  - pready=1 for exactly one cycle; prdata = registered rdata; pslverr = registered resp_err.
  - Then go to Idle. The counter clears on entry to Idle.
- pready is 0 in every state other than Done. The upstream therefore always sees at least one wait state.
- Latency, with upstream setup at cycle T:
  - Downstream setup at T+1; downstream access starts at T+2.
  - If m_pready=1 at T+2, upstream pready=1 at T+3.
  - Unmapped address: pready=1 at T+1.
- Upstream protocol: the upstream holds its signals stable through the access phase. The block samples them only in Idle. Upstream psel=0 in Setup, Access or Done is a protocol violation; it is asserted, not handled.
- m_pready and m_pslverr of non-selected subordinates are ignored.
- Exactly one m_psel bit is high in Setup and Access; m_psel is zero otherwise. This one-hot condition is asserted.
- Downstream outputs are driven from flops only; there is no combinational path from upstream inputs to m_* outputs.
- The counter is wide enough for TimeoutCycles and saturates; it does not wrap.
- Back-to-back transfers: a new upstream setup may appear in the cycle after Done and is accepted from Idle. The minimum mapped transfer period is 4 cycles.

Test Plan:
- Mapped read, default parameters: paddr=0x404, psel, subordinate 1 returns m_pready=1 on its first access cycle with m_prdata=0xDEADBEEF -> m_psel=4'b0010 at T+1, m_penable=1 at T+2, pready=1 with prdata=0xDEADBEEF and pslverr=0 at T+3.
- Mapped write with wait states: paddr=0xC10, pwdata=0x12345678, pstrb=4'hF; subordinate 3 inserts 3 wait cycles, then returns m_pslverr=1 -> m_pwdata=0x12345678 held stable throughout, pready=1 and pslverr=1 at T+6, m_psel=0 at T+6.
- Unmapped address: NumSubordinates=3, paddr=0xC00 -> no m_psel activity; pready=1, pslverr=1, prdata=0 at T+1.
- Timeout: TimeoutCycles=8, subordinate 0 never ready -> access lasts exactly 8 cycles; then pready=1, pslverr=1, prdata=0. The next transfer to subordinate 2 completes normally.
- Asynchronous reset mid-transfer: drive rst_n low during Access of subordinate 2 -> m_psel=0, m_penable=0 and pready=0 without waiting for a clock edge. After release, a new read to subordinate 0 completes in 3 cycles.
- Back-to-back: four consecutive zero-wait reads to subordinates 0,1,2,3 -> each completes with period 4 and correct per-index data; m_psel is never multi-hot.

Source files
------------

// File: rtl/br_amba_apb_demux.sv
// rtl/br_amba_apb_demux.sv - APB address-decode fan-out with local error termination and access timeout
package br_amba;
  localparam int ApbProtWidth = 3;
endpackage

module br_amba_apb_demux #(
  parameter int AddrWidth       = 12,
  parameter int DataWidth       = 32,
  parameter int NumSubordinates = 4,
  parameter int SubAddrWidth    = 10,
  parameter int TimeoutCycles   = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [AddrWidth-1:0]                 paddr,
  input  logic                                 psel,
  input  logic                                 penable,
  input  logic [br_amba::ApbProtWidth-1:0]     pprot,
  input  logic [DataWidth/8-1:0]               pstrb,
  input  logic                                 pwrite,
  input  logic [DataWidth-1:0]                 pwdata,
  output logic [DataWidth-1:0]                 prdata,
  output logic                                 pready,
  output logic                                 pslverr,
  output logic [NumSubordinates-1:0]           m_psel,
  output logic                                 m_penable,
  output logic [AddrWidth-1:0]                 m_paddr,
  output logic [br_amba::ApbProtWidth-1:0]     m_pprot,
  output logic [DataWidth/8-1:0]               m_pstrb,
  output logic                                 m_pwrite,
  output logic [DataWidth-1:0]                 m_pwdata,
  input  logic [NumSubordinates*DataWidth-1:0] m_prdata,
  input  logic [NumSubordinates-1:0]           m_pready,
  input  logic [NumSubordinates-1:0]           m_pslverr
);
  localparam int IdxWidth = $clog2(NumSubordinates);
  localparam int CntWidth = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SETUP  = 4'b0010,
    ACCESS = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t                state;
  logic [CntWidth-1:0]   count;
  logic [IdxWidth-1:0]   idx;
  logic                  mapped;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DataWidth-1:0]  sel_rdata;
  logic                  timed_out;

  assign idx    = paddr[SubAddrWidth +: IdxWidth];
  assign mapped = ({1'b0, idx} < (IdxWidth + 1)'(NumSubordinates));

  // The registered one-hot select doubles as the response mux, so the
  // ready/error/data of non-selected subordinates never reach the upstream.
  assign sel_ready = |(m_pready & m_psel);
  assign sel_err   = |(m_pslverr & m_psel);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NumSubordinates; i++) begin
      if (m_psel[i]) sel_rdata = sel_rdata | m_prdata[i*DataWidth +: DataWidth];
    end
  end

  assign timed_out = (TimeoutCycles != 0) && (count == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      m_psel    <= '0;
      m_penable <= 1'b0;
      m_paddr   <= '0;
      m_pprot   <= '0;
      m_pstrb   <= '0;
      m_pwrite  <= 1'b0;
      m_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            m_paddr  <= paddr;
            m_pprot  <= pprot;
            m_pstrb  <= pstrb;
            m_pwrite <= pwrite;
            m_pwdata <= pwdata;
            if (mapped) begin
              m_psel <= NumSubordinates'(1) << idx;
              state  <= SETUP;
            end else begin
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
              state   <= DONE;
            end
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (count != '1) count <= count + CntWidth'(1);
          if (sel_ready) begin
            pready    <= 1'b1;
            prdata    <= sel_rdata;
            pslverr   <= sel_err;
            m_psel    <= '0;
            m_penable <= 1'b0;
            state     <= DONE;
          end else if (timed_out) begin
            // Dropping m_psel mid-access aborts the hung subordinate.
            pready    <= 1'b1;
            prdata    <= '0;
            pslverr   <= 1'b1;
            m_psel    <= '0;
            m_penable <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          count   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_psel_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == SETUP || state == ACCESS) ? $onehot(m_psel) : (m_psel == '0)));

  a_upstream_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE || psel));

endmodule
